mem_responder: RTL and testbench

- Word-addressed memory responder on the memory side of the CPU datapath.
- Answers read/write requests issued by the CPU's address and data registers (MAR/MDR) with a fixed, parameterised wait-state latency and a busy/done handshake.
- Holds the program/data RAM internally.
- The MDR captures read data from rdata when done pulses.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_word_ram.sv | 19 +
 rtl/mem_responder.sv | 85 ++++++++
 tb/tb_mem_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the word-addressed memory responder.
package mem_pkg;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 9;
    localparam int MEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ERR   = 2'd2
    } op_t;

    // Conflicting requests and out-of-range addresses both collapse to OP_ERR.
    function automatic op_t decode_op(input logic rd, input logic wr, input logic oor);
        if ((rd && wr) || oor) return OP_ERR;
        return rd ? OP_READ : OP_WRITE;
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU MAR/MDR side and the memory responder.
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
);
    logic              req_read;
    logic              req_write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req_read, req_write, addr, wdata,
        input  busy, done, rdata, err
    );

    modport slave (
        input  req_read, req_write, addr, wdata,
        output busy, done, rdata, err
    );
endinterface

// File: rtl/mem_word_ram.sv
// Single-port word RAM: synchronous write, registered read that holds when re is low.
module mem_word_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: latches a MAR/MDR request, waits WAIT_CYCLES, performs one
// RAM access and pulses done (with err for illegal requests).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = MEM_DATA_W,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            clr,
    mem_responder_if.slave  bus
);
    state_t                 state;
    op_t                    op_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [MEM_CNT_W-1:0]   cnt;
    logic                   done_q;
    logic                   err_q;
    logic                   rd_zero;
    logic                   ram_we;
    logic                   ram_re;
    logic [DATA_W-1:0]      ram_q;
    logic                   oor;

    assign oor    = (bus.addr >> ADDR_W) != 32'd0;
    assign ram_we = (state == ACCESS) && (op_q == OP_WRITE);
    assign ram_re = (state == ACCESS) && (op_q == OP_READ);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_zero <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: if (bus.req_read || bus.req_write) begin
                    addr_q  <= bus.addr[ADDR_W-1:0];
                    wdata_q <= bus.wdata;
                    op_q    <= decode_op(bus.req_read, bus.req_write, oor);
                    cnt     <= MEM_CNT_W'(WAIT_CYCLES);
                    state   <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == MEM_CNT_W'(1)) state <= ACCESS;
                end
                ACCESS: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                    err_q  <= (op_q == OP_ERR);
                    if (op_q == OP_READ) rd_zero <= 1'b0;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The RAM output register has no reset; rd_zero masks it until the first read.
    assign bus.rdata = rd_zero ? '0 : ram_q;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;

    mem_word_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder with a queue/array reference model.
module tb_mem_responder;
    localparam int WA = 2;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // reference model: sparse memory plus last read value
    logic [31:0] mem_m [int];
    logic [31:0] last_rd = 32'd0;
    bit          rd_known = 1'b1;

    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(32)) bus_a ();
    mem_responder_if #(.DATA_W(32)) bus_b ();

    mem_responder #(.DATA_W(32), .ADDR_W(AW), .WAIT_CYCLES(WA)) dut_a (
        .clk (clk), .clr (clr), .bus (bus_a)
    );
    mem_responder #(.DATA_W(32), .ADDR_W(AW), .WAIT_CYCLES(0)) dut_b (
        .clk (clk), .clr (clr), .bus (bus_b)
    );

    function automatic bit is_err(input bit rd, input bit wr, input logic [31:0] a);
        return (rd && wr) || (a >= 32'(2**AW));
    endfunction

    function automatic void model_op(input bit rd, input bit wr, input logic [31:0] a,
                                     input logic [31:0] wd);
        if (is_err(rd, wr, a)) return;
        if (wr) mem_m[int'(a)] = wd;
        else if (mem_m.exists(int'(a))) begin
            last_rd  = mem_m[int'(a)];
            rd_known = 1'b1;
        end else rd_known = 1'b0;
    endfunction

    // Drives one request on bus_a and collects the response; no checking here.
    task automatic run_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] pa, input logic [31:0] pwd,
                          output int lat, output bit e, output logic [31:0] rdv,
                          output bit busy_after, output bit done_after);
        bit acc = 1'b0;
        lat = -1; e = 1'b0; rdv = '0; busy_after = 1'b1; done_after = 1'b1;
        bus_a.req_read = rd; bus_a.req_write = wr; bus_a.addr = a; bus_a.wdata = wd;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (bus_a.busy) acc = 1'b1;
        end
        bus_a.req_read = 1'b0; bus_a.req_write = 1'b0; bus_a.addr = pa; bus_a.wdata = pwd;
        if (!acc) return;
        for (int n = 1; n <= 20; n++) begin
            if (bus_a.done) begin
                lat = n; e = bus_a.err; rdv = bus_a.rdata;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) return;
        @(negedge clk);
        busy_after = bus_a.busy;
        done_after = bus_a.done;
    endtask

    task automatic test_reset();
        #1;
        total += 4;
        if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_a.busy); end
        if (bus_a.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus_a.done); end
        if (bus_a.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus_a.err); end
        if (bus_a.rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus_a.rdata); end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; bit e, ba, da; logic [31:0] rdv;
        run_op(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd5, 32'hDEAD_BEEF, lat, e, rdv, ba, da);
        model_op(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        total += 4;
        if (lat !== WA + 2) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", lat, WA + 2); end
        if (e !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", e); end
        if (ba !== 1'b0) begin bad++; $display("FAIL wr_busy_after got=%b want=0", ba); end
        if (da !== 1'b0) begin bad++; $display("FAIL wr_done_width got=%b want=0", da); end
        run_op(1'b1, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b1, 1'b0, 32'd5, 32'd0);
        total += 3;
        if (lat !== WA + 2) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", lat, WA + 2); end
        if (e !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", e); end
        if (rdv !== last_rd) begin bad++; $display("FAIL rd_data got=%h want=%h", rdv, last_rd); end
    endtask

    task automatic test_hold_change();
        int lat; bit e, ba, da; logic [31:0] rdv;
        run_op(1'b0, 1'b1, 32'd7, 32'h7777_7777, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b0, 1'b1, 32'd7, 32'h7777_7777);
        // inputs swing to addr=7/wdata=0 right after acceptance
        run_op(1'b0, 1'b1, 32'd5, 32'hCAFE_0005, 32'd7, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b0, 1'b1, 32'd5, 32'hCAFE_0005);
        run_op(1'b1, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b1, 1'b0, 32'd5, 32'd0);
        total++;
        if (rdv !== 32'hCAFE_0005) begin bad++; $display("FAIL hold_mem5 got=%h want=cafe0005", rdv); end
        run_op(1'b1, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b1, 1'b0, 32'd7, 32'd0);
        total++;
        if (rdv !== 32'h7777_7777) begin bad++; $display("FAIL hold_mem7 got=%h want=77777777", rdv); end
    endtask

    task automatic test_errors();
        int lat; bit e, ba, da; logic [31:0] rdv;
        run_op(1'b0, 1'b1, 32'd3, 32'h0000_3333, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b0, 1'b1, 32'd3, 32'h0000_3333);
        run_op(1'b0, 1'b1, 32'd0, 32'h0000_AAAA, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b0, 1'b1, 32'd0, 32'h0000_AAAA);
        run_op(1'b1, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b1, 1'b0, 32'd5, 32'd0);
        run_op(1'b1, 1'b1, 32'd3, 32'h0BAD_0BAD, 32'd0, 32'd0, lat, e, rdv, ba, da);
        total += 3;
        if (lat !== WA + 2) begin bad++; $display("FAIL both_latency got=%0d want=%0d", lat, WA + 2); end
        if (e !== 1'b1) begin bad++; $display("FAIL both_err got=%b want=1", e); end
        if (rdv !== last_rd) begin bad++; $display("FAIL both_rdata got=%h want=%h", rdv, last_rd); end
        run_op(1'b0, 1'b1, 32'h0000_0200, 32'h0000_5555, 32'd0, 32'd0, lat, e, rdv, ba, da);
        total += 2;
        if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b want=1", e); end
        if (rdv !== last_rd) begin bad++; $display("FAIL oor_wr_rdata got=%h want=%h", rdv, last_rd); end
        run_op(1'b1, 1'b0, 32'h8000_0001, 32'd0, 32'd0, 32'd0, lat, e, rdv, ba, da);
        total += 2;
        if (e !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b want=1", e); end
        if (rdv !== last_rd) begin bad++; $display("FAIL oor_rd_rdata got=%h want=%h", rdv, last_rd); end
        run_op(1'b1, 1'b0, 32'd3, 32'd0, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b1, 1'b0, 32'd3, 32'd0);
        total++;
        if (rdv !== 32'h0000_3333) begin bad++; $display("FAIL both_mem3 got=%h want=00003333", rdv); end
        run_op(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b1, 1'b0, 32'd0, 32'd0);
        total++;
        if (rdv !== 32'h0000_AAAA) begin bad++; $display("FAIL oor_alias_mem0 got=%h want=0000aaaa", rdv); end
    endtask

    task automatic test_reset_mid();
        int lat; bit e, ba, da; logic [31:0] rdv;
        run_op(1'b0, 1'b1, 32'd9, 32'h0000_0011, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b0, 1'b1, 32'd9, 32'h0000_0011);
        run_op(1'b1, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b1, 1'b0, 32'd5, 32'd0);
        bus_a.req_write = 1'b1; bus_a.addr = 32'd9; bus_a.wdata = 32'd1;
        @(negedge clk);
        bus_a.req_write = 1'b0;
        total++;
        if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL mid_accept_busy got=%b want=1", bus_a.busy); end
        #2 clr = 1'b0;
        #1;
        total += 4;
        if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus_a.busy); end
        if (bus_a.done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", bus_a.done); end
        if (bus_a.err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b want=0", bus_a.err); end
        if (bus_a.rdata !== 32'd0) begin bad++; $display("FAIL mid_rdata got=%h want=0", bus_a.rdata); end
        @(negedge clk);
        clr = 1'b1;
        last_rd = 32'd0; rd_known = 1'b1;
        run_op(1'b1, 1'b0, 32'd9, 32'd0, 32'd0, 32'd0, lat, e, rdv, ba, da);
        model_op(1'b1, 1'b0, 32'd9, 32'd0);
        total++;
        if (rdv !== 32'h0000_0011) begin bad++; $display("FAIL mid_mem9 got=%h want=00000011", rdv); end
    endtask

    task automatic test_random();
        int lat; bit e, ba, da, rd, wr, xe; logic [31:0] rdv, a, wd;
        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 9));
            a  = 32'($urandom_range(0, 15));
            if (kind == 0) a = 32'($urandom_range(16, 511));
            wd = $urandom;
            rd = $urandom_range(0, 1) == 1;
            wr = !rd;
            if (kind == 1) begin rd = 1'b1; wr = 1'b1; end
            if (kind == 2) a = a | ({17'($urandom_range(1, 65535)), 15'd0});
            xe = is_err(rd, wr, a);
            run_op(rd, wr, a, wd, $urandom, $urandom, lat, e, rdv, ba, da);
            model_op(rd, wr, a, wd);
            total += 4;
            if (lat !== WA + 2) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d want=%0d", i, lat, WA + 2); end
            if (e !== xe) begin bad++; $display("FAIL rnd_err[%0d] got=%b want=%b", i, e, xe); end
            if (ba !== 1'b0) begin bad++; $display("FAIL rnd_busy_after[%0d] got=%b want=0", i, ba); end
            if (da !== 1'b0) begin bad++; $display("FAIL rnd_done_width[%0d] got=%b want=0", i, da); end
            if (rd_known) begin
                total++;
                if (rdv !== last_rd) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", i, rdv, last_rd); end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] v = 32'hA5C3_0F1E;
        int ndone = 0;
        bus_b.req_write = 1'b1; bus_b.addr = 32'd4; bus_b.wdata = v;
        @(negedge clk);
        bus_b.req_write = 1'b0;
        @(negedge clk);
        total += 2;
        if (bus_b.done !== 1'b1) begin bad++; $display("FAIL zw_wr_done got=%b want=1", bus_b.done); end
        if (bus_b.err !== 1'b0) begin bad++; $display("FAIL zw_wr_err got=%b want=0", bus_b.err); end
        @(negedge clk);
        // request held continuously: one completion per W+3 cycles, first at W+2
        bus_b.req_read = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            bit want;
            @(negedge clk);
            want = (k >= 2) && ((k - 2) % 3 == 0);
            total++;
            if (bus_b.done !== want) begin bad++; $display("FAIL zw_done[%0d] got=%b want=%b", k, bus_b.done, want); end
            if (bus_b.done === 1'b1) begin
                ndone++;
                total++;
                if (bus_b.rdata !== v) begin bad++; $display("FAIL zw_rdata[%0d] got=%h want=%h", k, bus_b.rdata, v); end
            end
        end
        bus_b.req_read = 1'b0;
        total++;
        if (ndone != 10) begin bad++; $display("FAIL zw_count got=%0d want=10", ndone); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus_a.req_read = 1'b0; bus_a.req_write = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req_read = 1'b0; bus_b.req_write = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
        test_reset();
        test_write_read();
        test_hold_change();
        test_errors();
        test_reset_mid();
        test_random();
        test_zero_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
